// File: rtl/slt_seq_unit_pkg.sv
// Shared definitions for the sequential set-less-than unit: state encodings and default sizing.
// Imported by the RTL and by the bench so both agree on widths and state codes.
package slt_seq_unit_pkg;

    localparam int DEF_WIDTH = 64;
    localparam int DEF_CHUNK = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_DONE = 2'd2
    } slt_state_e;

endpackage

// File: rtl/slt_chunk_cmp.sv
// Purpose: single-chunk magnitude compare, optional MSB flip for signed top chunk.
// Latency: combinational.
// Backpressure: none, pure function of inputs.
module slt_chunk_cmp #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] ca,
    input  logic [CHUNK-1:0] cb,
    input  logic             flip_msb,
    output logic             lt,
    output logic             gt
);

    logic [CHUNK-1:0] msk;
    logic [CHUNK-1:0] ca_f;
    logic [CHUNK-1:0] cb_f;

    // Inverting the sign bit maps two's complement onto offset binary,
    // so an unsigned compare of the top chunk gives the signed ordering.
    assign msk  = CHUNK'(flip_msb) << (CHUNK - 1);
    assign ca_f = ca ^ msk;
    assign cb_f = cb ^ msk;
    assign lt   = (ca_f < cb_f);
    assign gt   = (ca_f > cb_f);

endmodule

// File: rtl/slt_seq_unit.sv
// Purpose: multi-cycle SLT/SLTU, CHUNK bits per cycle MSB-first, zero-extended 0/1 result plus equality.
// Latency: fixed WIDTH/CHUNK cycles from accept to out_valid; one request in flight.
// Backpressure: result held in DONE until out_ready; in_ready low while busy, requests then are dropped.
module slt_seq_unit
    import slt_seq_unit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_eq
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("slt_seq_unit: WIDTH must be a multiple of CHUNK");
    end

    slt_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             sgn_q, sgn_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             lt_q, lt_d, gt_q, gt_d;

    logic [WIDTH-1:0] a_sh, b_sh;
    logic             c_lt, c_gt;

    // Shifting by cnt chunks brings the current chunk to the top.
    assign a_sh = a_q << (int'(cnt_q) * CHUNK);
    assign b_sh = b_q << (int'(cnt_q) * CHUNK);

    slt_chunk_cmp #(.CHUNK(CHUNK)) u_cmp (
        .ca       (a_sh[WIDTH-1 -: CHUNK]),
        .cb       (b_sh[WIDTH-1 -: CHUNK]),
        .flip_msb (sgn_q && (cnt_q == '0)),
        .lt       (c_lt),
        .gt       (c_gt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            cnt_q   <= '0;
            lt_q    <= 1'b0;
            gt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            cnt_q   <= cnt_d;
            lt_q    <= lt_d;
            gt_q    <= gt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sgn_d     = sgn_q;
        cnt_d     = cnt_q;
        lt_d      = lt_q;
        gt_d      = gt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_y     = '0;
        out_eq    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    sgn_d   = in_signed;
                    cnt_d   = '0;
                    lt_d    = 1'b0;
                    gt_d    = 1'b0;
                    state_d = ST_CMP;
                end
            end
            ST_CMP: begin
                // First differing chunk decides; no early exit keeps latency fixed.
                if (!lt_q && !gt_q) begin
                    lt_d = c_lt;
                    gt_d = c_gt;
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(NCHUNK - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                out_y     = {{(WIDTH-1){1'b0}}, lt_q};
                out_eq    = !lt_q && !gt_q;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_slt_seq_unit.sv
// Directed bench for slt_seq_unit: driver pushes hand-computed results, monitor pops and compares on each result handshake.
module tb_slt_seq_unit;
    import slt_seq_unit_pkg::*;

    localparam int W  = DEF_WIDTH;
    localparam int NC = DEF_WIDTH / DEF_CHUNK;

    typedef struct {
        logic lt;
        logic eq;
        int   acc_cyc;
        string name;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_signed = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_y;
    logic         out_eq;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic prev_vld = 1'b0;
    exp_t sb[$];

    localparam logic [W-1:0] ONES    = {W{1'b1}};
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};

    slt_seq_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_signed (in_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_eq    (out_eq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    // Monitor: latency on the rising edge of out_valid, value compare on pop.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_vld = 1'b0;
        end else begin
            if (out_valid && !prev_vld) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", 1'b1, 1'b0);
                end else begin
                    chk({sb[0].name, "_latency"}, cyc - sb[0].acc_cyc, NC);
                end
            end
            if (out_valid && out_ready && sb.size() != 0) begin
                chk({sb[0].name, "_y"}, out_y, {{(W-1){1'b0}}, sb[0].lt});
                chk({sb[0].name, "_eq"}, out_eq, sb[0].eq);
                void'(sb.pop_front());
            end
            prev_vld = out_valid;
        end
    end

    task automatic send(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic elt, input logic eeq, input logic push);
        int n = 0;
        exp_t e;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) begin
            chk({nm, "_in_ready_timeout"}, 1'b0, 1'b1);
            return;
        end
        in_a = a; in_b = b; in_signed = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Scramble the operands after accept; the unit must not resample them.
        in_a = ~a; in_b = ~b; in_signed = ~s;
        if (push) begin
            e.lt = elt; e.eq = eeq; e.acc_cyc = cyc; e.name = nm;
            sb.push_back(e);
        end
    endtask

    task automatic wait_drain(input string nm);
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (sb.size() != 0) chk({nm, "_drain_timeout"}, 1'b0, 1'b1);
    endtask

    initial begin
        #2;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_y", out_y, '0);
        chk("rst_out_eq", out_eq, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        send("s_10_5",      64'd10, 64'd5, 1'b1, 1'b0, 1'b0, 1'b1);
        send("s_m5_3",      -64'sd5, 64'd3, 1'b1, 1'b1, 1'b0, 1'b1);
        send("u_m5_3",      -64'sd5, 64'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        send("s_m10_m20",   -64'sd10, -64'sd20, 1'b1, 1'b0, 1'b0, 1'b1);
        send("s_m10_m5",    -64'sd10, -64'sd5, 1'b1, 1'b1, 1'b0, 1'b1);
        send("s_eq_min",    MIN_NEG, MIN_NEG, 1'b1, 1'b0, 1'b1, 1'b1);
        send("u_lsb_1_2",   64'd1, 64'd2, 1'b0, 1'b1, 1'b0, 1'b1);
        send("s_0_ones",    '0, ONES, 1'b1, 1'b0, 1'b0, 1'b1);
        send("u_0_ones",    '0, ONES, 1'b0, 1'b1, 1'b0, 1'b1);
        send("s_min_max",   MIN_NEG, MAX_POS, 1'b1, 1'b1, 1'b0, 1'b1);
        send("u_min_max",   MIN_NEG, MAX_POS, 1'b0, 1'b0, 1'b0, 1'b1);
        send("u_lsb_gt",    64'h0123_4567_89ab_cdf0, 64'h0123_4567_89ab_cdef, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_drain("directed");

        // Backpressure: hold the result for 5 cycles.
        out_ready = 1'b0;
        send("bp_s_m5_3", -64'sd5, 64'd3, 1'b1, 1'b1, 1'b0, 1'b1);
        begin
            int n = 0;
            while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1'b1);
            chk("bp_out_y", out_y, 64'd1);
            chk("bp_in_ready", in_ready, 1'b0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_in_ready_after_pop", in_ready, 1'b1);
        send("bp_next", 64'd7, 64'd7, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_drain("bp");

        // Reset during CMP: no result must ever appear for this request.
        send("abort", 64'd1, 64'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("abort_rst_out_valid", out_valid, 1'b0);
        chk("abort_rst_out_y", out_y, '0);
        chk("abort_rst_out_eq", out_eq, 1'b0);
        chk("abort_rst_in_ready", in_ready, 1'b1);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("abort_release_in_ready", in_ready, 1'b1);
        repeat (NC + 2) begin
            @(negedge clk);
            chk("abort_no_result", out_valid, 1'b0);
        end
        send("post_rst_s_m5_3", -64'sd5, 64'd3, 1'b1, 1'b1, 1'b0, 1'b1);
        wait_drain("post_rst");
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete, %0d checks", checks);
        $fatal(1);
    end

endmodule
